// File: rtl/dom1_skinny_host_pkg.sv
// Shared constants, FSM encoding and load-frame layout
// for the DOM-1 Skinny-128-384+ host controller.
package dom1_skinny_host_pkg;

    localparam int BYTE_W    = 8;
    localparam int FIELD_W   = 128;
    localparam int IN_BYTES  = 112;
    localparam int OUT_BYTES = 32;
    localparam int TX_W      = IN_BYTES * BYTE_W;
    localparam int RX_W      = OUT_BYTES * BYTE_W;
    localparam int CNT_W     = 7;

    localparam logic [CNT_W-1:0] IN_LAST  = 7'(IN_BYTES - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = 7'(OUT_BYTES - 1);

    localparam int OFF_ST_SH1  = 6 * FIELD_W;
    localparam int OFF_ST_SH0  = 5 * FIELD_W;
    localparam int OFF_KEY_SH1 = 4 * FIELD_W;
    localparam int OFF_KEY_SH0 = 3 * FIELD_W;
    localparam int OFF_TWEAK   = 2 * FIELD_W;
    localparam int OFF_CNT     = 1 * FIELD_W;
    localparam int OFF_RSEED   = 0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COLLECT = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // A zero-seeded LFSR never leaves zero, so force a nonzero seed.
    function automatic logic [FIELD_W-1:0] fix_seed(
        input logic [FIELD_W-1:0] s
    );
        return (s == '0) ? FIELD_W'(1) : s;
    endfunction

endpackage

// File: rtl/dom1_skinny_host_ctrl_if.sv
// Byte-serial link between the host controller and the core:
// di carries the load frame in, do carries the masked result out.
interface dom1_skinny_host_ctrl_if;

    logic [7:0] core_di_data;
    logic       core_di_valid;
    logic       core_di_ready;
    logic [7:0] core_do_data;
    logic       core_do_valid;
    logic       core_do_ready;

    modport master (
        output core_di_data,
        output core_di_valid,
        input  core_di_ready,
        input  core_do_data,
        input  core_do_valid,
        output core_do_ready
    );

    modport slave (
        input  core_di_data,
        input  core_di_valid,
        output core_di_ready,
        output core_do_data,
        output core_do_valid,
        input  core_do_ready
    );

endinterface

// File: rtl/dom1_skinny_host_shreg.sv
// Byte-wide shift register with parallel load and read;
// shifts left by one byte, new byte enters at the LSB.
module dom1_skinny_host_shreg
    import dom1_skinny_host_pkg::*;
#(
    parameter int BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BYTES*BYTE_W-1:0] load_data,
    input  logic                    shift,
    input  logic [BYTE_W-1:0]       shift_in,
    output logic [BYTES*BYTE_W-1:0] q
);

    // Load has priority over shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[BYTES*BYTE_W-BYTE_W-1:0], shift_in};
        end
    end

endmodule

// File: rtl/dom1_skinny_host_ctrl.sv
// Host-side initiator: share-splits a request, streams the load frame
// to the core, gathers the masked result and recombines the shares.
module dom1_skinny_host_ctrl
    import dom1_skinny_host_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_pt,
    input  logic [127:0] req_key,
    input  logic [127:0] req_tweak,
    input  logic [127:0] req_cnt,
    input  logic [383:0] req_rand,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_ct,
    dom1_skinny_host_ctrl_if.master core
);

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]     cnt;
    logic [TX_W-1:0]      tx_ld;
    logic [TX_W-1:0]      tx_q;
    logic [RX_W-1:0]      rx_q;
    logic [RX_W-1:0]      rx_fin;
    logic [BYTE_W-1:0]    tx_head;
    logic [TX_W-9:0]      tx_tail_unused;
    logic [BYTE_W-1:0]    rx_top_unused;
    logic [FIELD_W-1:0]   st_m;
    logic [FIELD_W-1:0]   key_m;

    logic di_valid;
    logic do_ready;
    logic acc;
    logic di_fire;
    logic do_fire;
    logic rsp_fire;
    logic di_last;
    logic do_last;

    assign st_m  = req_rand[383:256];
    assign key_m = req_rand[255:128];

    assign {tx_head, tx_tail_unused} = tx_q;
    assign rx_top_unused = rx_q[RX_W-1 -: BYTE_W];
    assign rx_fin = {rx_q[RX_W-BYTE_W-1:0], core.core_do_data};

    assign acc      = req_valid & req_ready;
    assign di_fire  = di_valid & core.core_di_ready;
    assign do_fire  = do_ready & core.core_do_valid;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign di_last  = di_fire & (cnt == IN_LAST);
    assign do_last  = do_fire & (cnt == OUT_LAST);

    // Assemble the load frame; st_sh1 sits in the top bytes.
    always_comb begin
        tx_ld = '0;
        tx_ld[OFF_ST_SH1  +: FIELD_W] = req_pt ^ st_m;
        tx_ld[OFF_ST_SH0  +: FIELD_W] = st_m;
        tx_ld[OFF_KEY_SH1 +: FIELD_W] = req_key ^ key_m;
        tx_ld[OFF_KEY_SH0 +: FIELD_W] = key_m;
        tx_ld[OFF_TWEAK   +: FIELD_W] = req_tweak;
        tx_ld[OFF_CNT     +: FIELD_W] = req_cnt;
        tx_ld[OFF_RSEED   +: FIELD_W] = fix_seed(req_rand[127:0]);
    end

    dom1_skinny_host_shreg #(
        .BYTES (IN_BYTES)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (acc),
        .load_data (tx_ld),
        .shift     (di_fire),
        .shift_in  (8'h00),
        .q         (tx_q)
    );

    dom1_skinny_host_shreg #(
        .BYTES (OUT_BYTES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (acc),
        .load_data ('0),
        .shift     (do_fire),
        .shift_in  (core.core_do_data),
        .q         (rx_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (req_valid) state_nx = S_LOAD;
            S_LOAD:    if (di_last)   state_nx = S_COLLECT;
            S_COLLECT: if (do_last)   state_nx = S_RESP;
            S_RESP:    if (rsp_fire)  state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        req_ready = 1'b0;
        di_valid  = 1'b0;
        do_ready  = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            S_IDLE:    req_ready = 1'b1;
            S_LOAD:    di_valid  = 1'b1;
            S_COLLECT: do_ready  = 1'b1;
            S_RESP:    rsp_valid = 1'b1;
            default:   req_ready = 1'b0;
        endcase
        core.core_di_valid = di_valid;
        core.core_do_ready = do_ready;
        core.core_di_data  = di_valid ? tx_head : 8'h00;
    end

    // Byte counter, shared by the load and collect phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (acc || di_last || do_last) begin
            cnt <= '0;
        end else if (di_fire || do_fire) begin
            cnt <= cnt + 7'd1;
        end
    end

    // Recombine shares once, including the byte arriving now.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_ct <= '0;
        end else if (do_last) begin
            rsp_ct <= rx_fin[RX_W-1:FIELD_W] ^ rx_fin[FIELD_W-1:0];
        end
    end

endmodule

// File: tb/tb_dom1_skinny_host_ctrl.sv
// Self-checking bench for dom1_skinny_host_ctrl with a byte-level
// core stub and a field-level reference model of the load frame.
module tb_dom1_skinny_host_ctrl;
    import dom1_skinny_host_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_pt;
    logic [127:0] req_key;
    logic [127:0] req_tweak;
    logic [127:0] req_cnt;
    logic [383:0] req_rand;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_ct;

    dom1_skinny_host_ctrl_if cif ();

    dom1_skinny_host_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pt    (req_pt),
        .req_key   (req_key),
        .req_tweak (req_tweak),
        .req_cnt   (req_cnt),
        .req_rand  (req_rand),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_ct    (rsp_ct),
        .core      (cif)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] XV = 128'h00112233445566778899AABBCCDDEEFF;

    int checks = 0;
    int errors = 0;
    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ref_q[$];

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: share split from the rules, then fields MSB first.
    task automatic build_exp(input logic [127:0] pt, key, tw, cn,
                             input logic [383:0] rnd);
        logic [127:0] w[7];
        logic [127:0] seed;
        seed = rnd[127:0];
        if (seed == 0) seed = 128'd1;
        w[0] = pt ^ rnd[383:256];
        w[1] = rnd[383:256];
        w[2] = key ^ rnd[255:128];
        w[3] = rnd[255:128];
        w[4] = tw;
        w[5] = cn;
        w[6] = seed;
        exp_q.delete();
        for (int f = 0; f < 7; f++)
            for (int b = 15; b >= 0; b--)
                exp_q.push_back(w[f][8*b +: 8]);
    endtask

    function automatic int diffs(input logic [7:0] a[$],
                                 input logic [7:0] b[$]);
        int n = 0;
        if (a.size() != b.size()) return 1000;
        foreach (a[i]) if (a[i] !== b[i]) n++;
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        cif.core_di_ready = 1'b0;
        cif.core_do_valid = 1'b0;
        cif.core_do_data = 8'h00;
        req_pt = '0; req_key = '0; req_tweak = '0;
        req_cnt = '0; req_rand = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_req(input logic [127:0] pt, key, tw, cn,
                            input logic [383:0] rnd);
        int n = 0;
        req_pt = pt; req_key = key; req_tweak = tw;
        req_cnt = cn; req_rand = rnd; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b want 1", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load_frame(input bit stall, input int stop_at);
        int cyc = 0;
        bit tog = 1'b0;
        bit rdy;
        bit leak = 1'b0;
        bit moved = 1'b0;
        bit held_v = 1'b0;
        logic [7:0] held;
        frame_q.delete();
        checks++;
        if (cif.core_di_valid !== 1'b1) begin
            errors++;
            $display("FAIL di_latency: di_valid=%b want 1", cif.core_di_valid);
        end
        while (frame_q.size() < stop_at && cyc < 2000) begin
            rdy = stall ? tog : 1'b1;
            tog = ~tog;
            cif.core_di_ready = rdy;
            cif.core_do_valid = 1'($urandom_range(0, 1));
            cif.core_do_data = 8'($urandom);
            if (cif.core_do_ready !== 1'b0) leak = 1'b1;
            if (held_v && cif.core_di_data !== held) moved = 1'b1;
            held_v = cif.core_di_valid && !rdy;
            held = cif.core_di_data;
            if (cif.core_di_valid && rdy) frame_q.push_back(cif.core_di_data);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        cif.core_di_ready = 1'b0;
        cif.core_do_valid = 1'b0;
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL load_timeout: got %0d bytes want %0d", frame_q.size(), stop_at);
        end
        checks++;
        if (leak || moved) begin
            errors++;
            $display("FAIL load_rules: do_ready_leak=%b di_data_moved=%b want 0 0", leak, moved);
        end
    endtask

    task automatic collect_frame(input logic [127:0] x, m, input bit gaps);
        logic [255:0] r;
        int i = 0;
        int cyc = 0;
        bit v;
        r = {x ^ m, m};
        while (i < OUT_BYTES && cyc < 2000) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cif.core_do_valid = v;
            cif.core_do_data = r[255 - 8*i -: 8];
            if (v && cif.core_do_ready === 1'b1) i++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        cif.core_do_valid = 1'b0;
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL collect_timeout: got %0d bytes want %0d", i, OUT_BYTES);
        end
    endtask

    task automatic finish_rsp(output logic [127:0] ct);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ct = rsp_ct;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_txn(input logic [127:0] pt, key, tw, cn,
                           input logic [383:0] rnd,
                           input logic [127:0] m,
                           input bit stall, gaps,
                           output logic [127:0] ct);
        build_exp(pt, key, tw, cn, rnd);
        send_req(pt, key, tw, cn, rnd);
        load_frame(stall, IN_BYTES);
        collect_frame(XV, m, gaps);
        finish_rsp(ct);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: %b want 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: %b want 0", rsp_valid); end
        checks++;
        if (rsp_ct !== '0) begin errors++; $display("FAIL rst_rsp_ct: %h want 0", rsp_ct); end
        checks++;
        if (cif.core_di_valid !== 1'b0 || cif.core_di_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_di: valid=%b data=%h want 0 00", cif.core_di_valid, cif.core_di_data);
        end
        checks++;
        if (cif.core_do_ready !== 1'b0) begin errors++; $display("FAIL rst_do_ready: %b want 0", cif.core_do_ready); end
    endtask

    task automatic test_share_pattern();
        logic [383:0] rnd;
        logic [127:0] ct;
        rnd = {{16{8'hA5}}, r128(), r128() | 128'h1};
        build_exp('0, '0, r128(), r128(), rnd);
        send_req('0, '0, exp_q.size() > 0 ? {exp_q[64], 120'h0} : '0, '0, rnd);
        build_exp('0, '0, {exp_q[64], 120'h0}, '0, rnd);
        load_frame(1'b0, IN_BYTES);
        checks++;
        if (frame_q.size() != IN_BYTES) begin errors++; $display("FAIL frame_len: %0d want %0d", frame_q.size(), IN_BYTES); end
        checks++;
        if (frame_q[0] !== 8'hA5) begin errors++; $display("FAIL byte0: %h want a5", frame_q[0]); end
        checks++;
        if (frame_q[16] !== 8'hA5) begin errors++; $display("FAIL byte16: %h want a5", frame_q[16]); end
        checks++;
        if (diffs(frame_q, exp_q) != 0) begin errors++; $display("FAIL frame_share: %0d diffs want 0", diffs(frame_q, exp_q)); end
        checks++;
        if (cif.core_di_valid !== 1'b0 || cif.core_do_ready !== 1'b1) begin
            errors++;
            $display("FAIL to_collect: di_valid=%b do_ready=%b want 0 1", cif.core_di_valid, cif.core_do_ready);
        end
        collect_frame(XV, r128(), 1'b0);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_latency: rsp_valid=%b want 1", rsp_valid); end
        finish_rsp(ct);
        checks++;
        if (ct !== XV) begin errors++; $display("FAIL ct_share: %h want %h", ct, XV); end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_done: rsp_valid=%b req_ready=%b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_recombine();
        logic [127:0] m;
        logic [127:0] ct;
        for (int k = 0; k < 3; k++) begin
            m = (k == 0) ? '0 : (k == 1) ? '1 : r128();
            run_txn(r128(), r128(), r128(), r128(),
                    {r128(), r128(), r128()}, m, 1'b0, 1'b1, ct);
            checks++;
            if (ct !== XV) begin errors++; $display("FAIL ct_mask%0d: %h want %h", k, ct, XV); end
            checks++;
            if (diffs(frame_q, exp_q) != 0) begin errors++; $display("FAIL frame_mask%0d: %0d diffs want 0", k, diffs(frame_q, exp_q)); end
        end
    endtask

    task automatic test_seed();
        logic [127:0] one;
        logic [127:0] dead;
        logic [127:0] ct;
        logic [127:0] got;
        one = 128'd1;
        dead = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        run_txn(r128(), r128(), r128(), r128(),
                {r128(), r128(), 128'h0}, r128(), 1'b0, 1'b0, ct);
        got = '0;
        for (int i = 0; i < 16; i++) got = {got[119:0], frame_q[96 + i]};
        checks++;
        if (got !== one) begin errors++; $display("FAIL seed_zero: %h want %h", got, one); end
        run_txn(r128(), r128(), r128(), r128(),
                {r128(), r128(), dead}, r128(), 1'b0, 1'b0, ct);
        got = '0;
        for (int i = 0; i < 16; i++) got = {got[119:0], frame_q[96 + i]};
        checks++;
        if (got !== dead) begin errors++; $display("FAIL seed_pass: %h want %h", got, dead); end
        checks++;
        if (ct !== XV) begin errors++; $display("FAIL ct_seed: %h want %h", ct, XV); end
    endtask

    task automatic test_stall();
        logic [127:0] pt, key, tw, cn;
        logic [383:0] rnd;
        logic [127:0] ct;
        logic [127:0] ct0;
        bit moved = 1'b0;
        bit rdy_bad = 1'b0;
        pt = r128(); key = r128(); tw = r128(); cn = r128();
        rnd = {r128(), r128(), r128()};
        run_txn(pt, key, tw, cn, rnd, r128(), 1'b0, 1'b0, ct);
        ref_q = frame_q;
        send_req(pt, key, tw, cn, rnd);
        load_frame(1'b1, IN_BYTES);
        checks++;
        if (diffs(frame_q, ref_q) != 0) begin errors++; $display("FAIL stall_seq: %0d diffs want 0", diffs(frame_q, ref_q)); end
        checks++;
        if (diffs(frame_q, exp_q) != 0) begin errors++; $display("FAIL stall_model: %0d diffs want 0", diffs(frame_q, exp_q)); end
        collect_frame(XV, r128(), 1'b1);
        ct0 = rsp_ct;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_ct !== ct0) moved = 1'b1;
            if (req_ready !== 1'b0) rdy_bad = 1'b1;
        end
        checks++;
        if (moved || rdy_bad) begin
            errors++;
            $display("FAIL rsp_hold: moved=%b req_ready_seen=%b want 0 0", moved, rdy_bad);
        end
        finish_rsp(ct);
        checks++;
        if (ct !== XV) begin errors++; $display("FAIL ct_stall: %h want %h", ct, XV); end
    endtask

    task automatic test_abort();
        logic [127:0] ct;
        build_exp(r128(), r128(), r128(), r128(), {r128(), r128(), r128()});
        send_req(r128(), r128(), r128(), r128(), {r128(), r128(), r128()});
        load_frame(1'b0, 50);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_ct !== '0 ||
            cif.core_di_valid !== 1'b0 || cif.core_di_data !== 8'h00 ||
            cif.core_do_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: rr=%b rv=%b ct=%h dv=%b dd=%h dr=%b want 1 0 0 0 00 0",
                     req_ready, rsp_valid, rsp_ct, cif.core_di_valid,
                     cif.core_di_data, cif.core_do_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        run_txn(r128(), r128(), r128(), r128(),
                {r128(), r128(), r128()}, r128(), 1'b0, 1'b0, ct);
        checks++;
        if (diffs(frame_q, exp_q) != 0) begin errors++; $display("FAIL abort_restart: %0d diffs want 0", diffs(frame_q, exp_q)); end
        checks++;
        if (ct !== XV) begin errors++; $display("FAIL ct_abort: %h want %h", ct, XV); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pb, kb, tb_, cb;
        logic [383:0] rb;
        logic [7:0] exp_b[$];
        logic [127:0] ct_a;
        logic [127:0] ct_b;
        pb = r128(); kb = r128(); tb_ = r128(); cb = r128();
        rb = {r128(), r128(), r128()};
        build_exp(pb, kb, tb_, cb, rb);
        exp_b = exp_q;
        build_exp(r128(), r128(), r128(), r128(), {r128(), r128(), r128()});
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_pt = '0; req_key = '0; req_tweak = '0; req_cnt = '0; req_rand = '0;
        run_b2b_first(pb, kb, tb_, cb, rb, ct_a);
        checks++;
        if (ct_a !== XV) begin errors++; $display("FAIL b2b_ct_a: %h want %h", ct_a, XV); end
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: req_ready=%b rsp_valid=%b want 1 0", req_ready, rsp_valid);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        load_frame(1'b0, IN_BYTES);
        checks++;
        if (diffs(frame_q, exp_b) != 0) begin errors++; $display("FAIL b2b_frame_b: %0d diffs want 0", diffs(frame_q, exp_b)); end
        collect_frame(XV, r128(), 1'b0);
        finish_rsp(ct_b);
        checks++;
        if (ct_b !== XV) begin errors++; $display("FAIL b2b_ct_b: %h want %h", ct_b, XV); end
    endtask

    // First transfer of the back-to-back pair; leaves B queued on req.
    task automatic run_b2b_first(input logic [127:0] pb, kb, tb_, cb,
                                 input logic [383:0] rb,
                                 output logic [127:0] ct_a);
        req_pt = r128(); req_key = r128(); req_tweak = r128();
        req_cnt = r128(); req_rand = {r128(), r128(), r128()};
        build_exp(req_pt, req_key, req_tweak, req_cnt, req_rand);
        @(posedge clk);
        @(negedge clk);
        req_pt = pb; req_key = kb; req_tweak = tb_;
        req_cnt = cb; req_rand = rb;
        load_frame(1'b0, IN_BYTES);
        checks++;
        if (diffs(frame_q, exp_q) != 0) begin errors++; $display("FAIL b2b_frame_a: %0d diffs want 0", diffs(frame_q, exp_q)); end
        collect_frame(XV, r128(), 1'b0);
        ct_a = rsp_ct;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [127:0] ct;
        for (int k = 0; k < 4; k++) begin
            run_txn(r128(), r128(), r128(), r128(),
                    {r128(), r128(), r128()}, r128(),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ct);
            checks++;
            if (diffs(frame_q, exp_q) != 0 || ct !== XV) begin
                errors++;
                $display("FAIL rand%0d: diffs=%0d ct=%h want 0 %h", k, diffs(frame_q, exp_q), ct, XV);
            end
        end
    endtask

    initial begin
        test_reset();
        test_share_pattern();
        test_recombine();
        test_seed();
        test_stall();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
